if_fetch_unit: RTL and testbench

//  Instruction-fetch stage; producer side of the IF/ID pipeline register.

---
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: request/ready address phase, rvalid data phase.
// The fetch unit is the master side and the memory is the slave side.
interface if_fetch_unit_if #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight at most,
// and presents {instruction_out, pc_out, fetch_valid} to the IF/ID register.
module if_fetch_unit #(
  parameter int                     PC_WIDTH    = 64,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   PCSrcD_Control,
  input  logic [PC_WIDTH-1:0]    branch_target,
  if_fetch_unit_if.master        imem,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   fetch_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DROP
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
  logic                   valid_q, valid_d;

  logic [PC_WIDTH-1:0] redirect_pc;
  assign redirect_pc = {branch_target[PC_WIDTH-1:2], 2'b00};

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path can leave
    // one unassigned and infer a latch; always_comb uses blocking '='.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;

    if (PCSrcD_Control) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        // A request accepted in the redirect cycle is stale; its data must be drained.
        if (PCSrcD_Control) state_d = imem.imem_ready ? S_DROP : S_REQ;
        else if (imem.imem_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (PCSrcD_Control) begin
          state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        end else if (imem.imem_rvalid) begin
          instr_d  = imem.imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_WIDTH'(4);
          state_d  = S_VALID;
        end
      end

      S_VALID: begin
        if (PCSrcD_Control) begin
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end
      end

      // Leave on the stale response even if another redirect lands the same cycle,
      // otherwise the FSM would wait for a response that never comes.
      S_DROP: if (imem.imem_rvalid) state_d = S_REQ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update together.
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign imem.imem_req   = (state_q == S_REQ);
  assign imem.imem_addr  = pc_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign fetch_valid     = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit: a behavioural memory and a
// program-order model predict every consumed bundle and every request address.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst, stall, pcsrc;
  logic [63:0] target;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        fv;

  if_fetch_unit_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  if_fetch_unit #(
    .PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrcD_Control(pcsrc),
    .branch_target(target), .imem(bus), .instruction_out(instr_out),
    .pc_out(pc_out), .fetch_valid(fv)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Memory model: one pending slot (the DUT may only have one outstanding read).
  bit          rand_mode = 0;
  int          lat_dir = 1;
  bit          pend_valid = 0;
  logic [63:0] pend_addr = '0;
  int          pend_cnt = 0;

  // Program-order model: PC of the next bundle that should be delivered.
  logic [63:0] exp_pc = RST_PC;
  int          n_consumed = 0;
  bit          hold = 0;
  logic [63:0] prev_pc;
  logic [31:0] prev_instr;

  logic        s_req, s_fv;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h1122_3344;
    if (a == 64'h4) return 32'h5566_7788;
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bus.imem_ready  = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    bus.imem_rvalid = pend_valid && (pend_cnt == 0);
    bus.imem_rdata  = bus.imem_rvalid ? mem_word(pend_addr) : $urandom();
    @(negedge clk);
    s_req = bus.imem_req; s_addr = bus.imem_addr;
    s_fv = fv; s_pc = pc_out; s_instr = instr_out;
    if (!rst) begin
      if (s_req === 1'b1) begin
        check("one_outstanding", 64'(pend_valid), 64'd0);
        check("req_addr", s_addr, exp_pc);
        check("req_while_valid", 64'(s_fv), 64'd0);
      end
      if (s_fv !== 1'b1) check("bubble_instr", 64'(s_instr), 64'(NOP));
      if (hold) begin
        check("hold_valid", 64'(s_fv), 64'd1);
        check("hold_pc", s_pc, prev_pc);
        check("hold_instr", 64'(s_instr), 64'(prev_instr));
      end
      if (s_fv === 1'b1 && !stall && !pcsrc) begin
        check("bundle_pc", s_pc, exp_pc);
        check("bundle_instr", 64'(s_instr), 64'(mem_word(exp_pc)));
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_pc = RST_PC;
      hold   = 0;
    end else begin
      if (s_fv === 1'b1 && !stall && !pcsrc) n_consumed++;
      if (pcsrc) exp_pc = {target[63:2], 2'b00};
      else if (s_fv === 1'b1 && !stall) exp_pc = exp_pc + 64'd4;
      hold = (s_fv === 1'b1) && stall && !pcsrc;
      prev_pc = s_pc; prev_instr = s_instr;
    end
    if (bus.imem_rvalid) pend_valid = 0;
    else if (pend_valid) pend_cnt--;
    if (s_req === 1'b1 && bus.imem_ready) begin
      pend_valid = 1;
      pend_addr  = s_addr;
      pend_cnt   = (rand_mode ? int'($urandom_range(1, 3)) : lat_dir) - 1;
    end
    #1;
  endtask

  task automatic wait_fv(input string tag, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      got = (s_fv === 1'b1);
    end
    check(tag, 64'(got), 64'd1);
  endtask

  initial begin
    bit prog;
    int start;

    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; target = '0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    @(posedge clk); #1;

    // T1: reset values, then first request one cycle after reset falls
    tick();
    check("t1_fv", 64'(s_fv), 64'd0);
    check("t1_instr", 64'(s_instr), 64'(NOP));
    check("t1_req", 64'(s_req), 64'd0);
    check("t1_pc_out", s_pc, 64'd0);
    rst = 1'b0;
    tick();
    check("t1_idle_req", 64'(s_req), 64'd0);
    tick();
    check("t1_first_req", 64'(s_req), 64'd1);
    check("t1_first_addr", s_addr, RST_PC);

    // T2: back-to-back sequential fetches with 1-cycle latency
    tick();
    check("t2_wait_fv", 64'(s_fv), 64'd0);
    tick();
    check("t2_fv0", 64'(s_fv), 64'd1);
    check("t2_pc0", s_pc, 64'h0);
    check("t2_instr0", 64'(s_instr), 64'h1122_3344);
    tick();
    check("t2_pulse", 64'(s_fv), 64'd0);
    check("t2_req4", s_addr, 64'h4);
    tick();
    tick();
    check("t2_pc4", s_pc, 64'h4);
    check("t2_instr4", 64'(s_instr), 64'h5566_7788);

    // T3: stall in VALID holds the bundle and blocks new requests
    stall = 1'b1;
    wait_fv("t3_reach_valid", 8);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_hold_pc", s_pc, 64'h8);
      check("t3_hold_instr", 64'(s_instr), 64'(mem_word(64'h8)));
      check("t3_no_req", 64'(s_req), 64'd0);
    end
    stall = 1'b0; lat_dir = 2;
    tick();
    check("t3_release", 64'(s_fv), 64'd1);
    tick();
    check("t3_next_req", s_addr, 64'hC);

    // T4: redirect in WAIT before rvalid; returned data is discarded
    pcsrc = 1'b1; target = 64'h1234_5678_90AB_CDEF;
    tick();
    pcsrc = 1'b0; lat_dir = 1;
    tick();
    check("t4_drop_fv", 64'(s_fv), 64'd0);
    check("t4_drop_req", 64'(s_req), 64'd0);
    tick();
    check("t4_new_req", 64'(s_req), 64'd1);
    check("t4_new_addr", s_addr, 64'h1234_5678_90AB_CDEC);

    // T5: redirect and stall together in VALID
    stall = 1'b1;
    wait_fv("t5_reach_valid", 6);
    pcsrc = 1'b1; target = 64'h0000_0000_0000_1000;
    tick();
    pcsrc = 1'b0;
    tick();
    check("t5_killed", 64'(s_fv), 64'd0);
    check("t5_req", 64'(s_req), 64'd1);
    check("t5_addr", s_addr, 64'h1000);
    stall = 1'b0;

    // T6: PC wrap, then reset while a read is outstanding
    pcsrc = 1'b1; target = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    pcsrc = 1'b0;
    tick();
    check("t6_req_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_fv("t6_fv_top", 6);
    check("t6_pc_top", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    lat_dir = 2;
    tick();
    check("t6_wrap_addr", s_addr, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; lat_dir = 1;
    tick();
    check("t6_late_rvalid_seen", 64'(bus.imem_rvalid), 64'd1);
    check("t6_idle_fv", 64'(s_fv), 64'd0);
    check("t6_idle_req", 64'(s_req), 64'd0);
    tick();
    check("t6_restart_req", 64'(s_req), 64'd1);
    check("t6_restart_addr", s_addr, RST_PC);

    // Randomized traffic: random ready, latency, stalls and redirects
    rand_mode = 1;
    for (int n = 0; n < 150; n++) begin
      start = n_consumed;
      prog  = 0;
      for (int c = 0; c < 60 && !prog; c++) begin
        stall  = ($urandom_range(0, 9) < 3);
        pcsrc  = ($urandom_range(0, 99) < 6);
        target = ($urandom_range(0, 3) == 0) ? {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom())}
                                             : {$urandom(), $urandom()};
        tick();
        prog = (n_consumed != start);
      end
      check("rand_progress", 64'(prog), 64'd1);
    end
    stall = 1'b0; pcsrc = 1'b0; rand_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
